// File: rtl/eth_tx_scheduler.sv
// eth_tx_scheduler: two-requester round-robin front end for the RGMII transmit
// frame engine. A winner's size/LFSR/gap settings are captured and held for
// the whole frame. The engine sees a START_HOLD-cycle start level. Completion
// (busy falls) or a missing busy response (timeout) is reported back to the
// requester with a one-cycle pulse in the same cycle the grant drops.
module eth_tx_scheduler #(
  parameter int unsigned START_HOLD   = 4,
  parameter int unsigned BUSY_TIMEOUT = 64
) (
  input  logic        i_eth_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req,
  input  logic [15:0] i_size0,
  input  logic [15:0] i_size1,
  input  logic [1:0]  i_lfsr_en,
  input  logic [7:0]  i_gap0,
  input  logic [7:0]  i_gap1,
  input  logic        i_eth_busy,
  output logic        o_eth_tx_start,
  output logic [15:0] o_eth_tx_size,
  output logic        o_eth_tx_lfsr_enable,
  output logic [7:0]  o_gap_count,
  output logic [1:0]  o_grant,
  output logic        o_sel,
  output logic [1:0]  o_done,
  output logic [1:0]  o_err
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  // Terminal counts: the hold counter starts at 0 on the first start-high
  // cycle, the timeout counter at 0 on the first cycle after start falls.
  localparam logic [7:0]  HOLD_LAST = 8'(START_HOLD - 1);
  localparam logic [15:0] TO_LAST   = 16'(BUSY_TIMEOUT - 1);

  // Round-robin pick: a lone requester wins; on a tie the one that was not
  // served last wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) begin
      return ~last;
    end
    return req[1];
  endfunction

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] to_q, to_d;
  logic        start_q, start_d;
  logic [15:0] size_q, size_d;
  logic        lfsr_q, lfsr_d;
  logic [7:0]  gap_q, gap_d;
  logic [1:0]  grant_q, grant_d;
  logic        sel_q, sel_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  err_q, err_d;
  // The arbitration decision is registered one cycle before the launch, so a
  // request sampled at one edge is granted at the following edge.
  logic        pend_q, pend_d;
  logic        pend_idx_q, pend_idx_d;

  // State, counters and every output register; reset returns all to idle/0.
  always_ff @(posedge i_eth_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
      to_q    <= '0;
      start_q <= 1'b0;
      size_q  <= '0;
      lfsr_q  <= 1'b0;
      gap_q   <= '0;
      grant_q <= '0;
      sel_q   <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
      start_q <= start_d;
      size_q  <= size_d;
      lfsr_q  <= lfsr_d;
      gap_q   <= gap_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  // Pending winner index; only consumed while pend_q is set, so no reset.
  always_ff @(posedge i_eth_clk) begin
    pend_idx_q <= pend_idx_d;
  end

  // Next-state and output logic for arbitration, start shaping and tracking.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    hold_d     = hold_q;
    to_d       = to_q;
    start_d    = start_q;
    size_d     = size_q;
    lfsr_d     = lfsr_q;
    gap_d      = gap_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    done_d     = '0;
    err_d      = '0;
    pend_d     = pend_q;
    pend_idx_d = pend_idx_q;

    case (state_q)
      S_IDLE: begin
        start_d = 1'b0;
        grant_d = '0;
        if (pend_q) begin
          pend_d  = 1'b0;
          sel_d   = pend_idx_q;
          grant_d = pend_idx_q ? 2'b10 : 2'b01;
          size_d  = pend_idx_q ? i_size1 : i_size0;
          gap_d   = pend_idx_q ? i_gap1 : i_gap0;
          lfsr_d  = i_lfsr_en[pend_idx_q];
          start_d = 1'b1;
          hold_d  = '0;
          state_d = S_START;
        end else if (!i_eth_busy && (i_req != 2'b00)) begin
          // Busy high also covers an unlocked engine PLL: never launch then.
          pend_d     = 1'b1;
          pend_idx_d = rr_pick(i_req, last_q);
        end
      end

      S_START: begin
        if (hold_q == HOLD_LAST) begin
          start_d = 1'b0;
          to_d    = '0;
          state_d = S_WAIT_BUSY;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end

      S_WAIT_BUSY: begin
        if (i_eth_busy) begin
          state_d = S_WAIT_DONE;
        end else if (to_q == TO_LAST) begin
          err_d   = sel_q ? 2'b10 : 2'b01;
          grant_d = '0;
          last_d  = sel_q;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 16'd1;
        end
      end

      S_WAIT_DONE: begin
        // Frame length is not bounded here, so there is no timeout.
        if (!i_eth_busy) begin
          done_d  = sel_q ? 2'b10 : 2'b01;
          grant_d = '0;
          last_d  = sel_q;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_eth_tx_start       = start_q;
  assign o_eth_tx_size        = size_q;
  assign o_eth_tx_lfsr_enable = lfsr_q;
  assign o_gap_count          = gap_q;
  assign o_grant              = grant_q;
  assign o_sel                = sel_q;
  assign o_done               = done_q;
  assign o_err                = err_q;

endmodule
